// File: rtl/maria_dl_fetch_v2.sv
// Maria display-list fetch engine: walks the DLL and zone display lists and
// fetches direct/indirect graphics bytes into a small valid/ready output FIFO.
module maria_dl_fetch_v2 #(
  parameter int unsigned AW         = 16,
  parameter int unsigned WAIT_RAM   = 2,
  parameter int unsigned WAIT_ROM   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic          dll_reload,
  input  logic          abort,
  input  logic [AW-1:0] zp,
  input  logic [7:0]    char_base,
  input  logic          char_width,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic [7:0]    mem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [7:0]    out_hpos,
  output logic [2:0]    out_pal,
  output logic          out_wm,
  output logic          out_newobj,
  output logic          busy,
  output logic          dli,
  output logic [9:0]    cycles
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] RAM_LAST  = CW'(WAIT_RAM - 1);
  localparam logic [CW-1:0] ROM_LAST  = CW'(WAIT_ROM - 1);
  localparam logic [CW-1:0] ROM2_LAST = CW'(2 * WAIT_ROM - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DLL0, S_DLL1, S_DLL2, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_HDR4,
    S_IND_PTR, S_IND_BYTE, S_DIRECT, S_HOLE, S_FIN
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] hpos;
    logic [2:0] pal;
    logic       wm;
    logic       newobj;
  } fifo_ent_t;

  state_e        state_q;
  logic [CW-1:0] wait_q;
  logic [AW-1:0] dll_ptr_q, mem_addr_q;
  logic [15:0]   dp_q, dl_ptr_q, gaddr_q;
  logic [3:0]    offset_q;
  logic          dli_q, a12en_q, a11en_q;
  logic [7:0]    lo_q, base_q, hpos_q, char_q;
  logic          hole_q, five_q, ind_q, wm_q, second_q, newobj_q;
  logic [2:0]    pal_q;
  logic [4:0]    w_q;
  logic [5:0]    cnt_q;
  logic          busy_q, mem_req_q;
  logic [9:0]    cycles_q;

  fifo_ent_t     fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   fifo_cnt_q;

  logic [7:0] off8, char_hi, h_chk;
  logic       hole_hit, full, pop, stall, abort_hit, push;
  fifo_ent_t  push_ent, head;

  // Holey-zone check is evaluated when the header high byte arrives.
  always_comb begin
    off8     = {4'b0, offset_q};
    char_hi  = char_base + off8;
    h_chk    = ind_q ? char_hi : mem_data + off8;
    hole_hit = h_chk[7] & ((h_chk[3] & a11en_q) | (h_chk[4] & a12en_q));
  end

  assign full      = (fifo_cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop       = ce & out_valid & out_ready;
  assign stall     = full & ~pop;
  assign abort_hit = ce & abort & (state_q != S_IDLE) & (state_q != S_FIN) &
                     (state_q != S_DLL0) & (state_q != S_DLL1) & (state_q != S_DLL2);
  assign push      = ce & ~abort_hit & ~stall & (wait_q == ROM_LAST) &
                     ((state_q == S_DIRECT) | (state_q == S_IND_BYTE));
  assign push_ent  = '{data: mem_data, hpos: hpos_q, pal: pal_q, wm: wm_q, newobj: newobj_q};
  assign head      = fifo_q[rd_ptr_q];

  assign mem_addr   = mem_addr_q;
  assign mem_req    = mem_req_q;
  assign busy       = busy_q;
  assign dli        = dli_q;
  assign cycles     = cycles_q;
  assign out_valid  = (fifo_cnt_q != '0);
  assign out_data   = head.data;
  assign out_hpos   = head.hpos;
  assign out_pal    = head.pal;
  assign out_wm     = head.wm;
  assign out_newobj = head.newobj;

  // Fetch sequencer; every access holds its address until the wait count expires.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      dll_ptr_q  <= '0;
      mem_addr_q <= '0;
      dp_q       <= '0;
      dl_ptr_q   <= '0;
      gaddr_q    <= '0;
      offset_q   <= '0;
      dli_q      <= 1'b0;
      a12en_q    <= 1'b0;
      a11en_q    <= 1'b0;
      lo_q       <= '0;
      base_q     <= '0;
      hpos_q     <= '0;
      char_q     <= '0;
      hole_q     <= 1'b0;
      five_q     <= 1'b0;
      ind_q      <= 1'b0;
      wm_q       <= 1'b0;
      second_q   <= 1'b0;
      newobj_q   <= 1'b0;
      pal_q      <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      cycles_q   <= '0;
    end else if (ce) begin
      if (busy_q && cycles_q != 10'h3FF) cycles_q <= cycles_q + 10'd1;
      wait_q <= wait_q + CW'(1);
      if (abort_hit) begin
        wait_q <= '0;
        if (offset_q != 4'd0) begin
          offset_q  <= offset_q - 4'd1;
          state_q   <= S_FIN;
          mem_req_q <= 1'b0;
        end else begin
          state_q    <= S_DLL0;
          mem_addr_q <= dll_ptr_q;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            wait_q <= '0;
            if (start && !abort) begin
              busy_q    <= 1'b1;
              cycles_q  <= '0;
              mem_req_q <= 1'b1;
              if (dll_reload) begin
                dll_ptr_q  <= zp;
                mem_addr_q <= zp;
                state_q    <= S_DLL0;
              end else begin
                dl_ptr_q   <= dp_q;
                mem_addr_q <= AW'(dp_q);
                state_q    <= S_HDR0;
              end
            end
          end
          S_DLL0, S_DLL1, S_DLL2: begin
            if (wait_q == RAM_LAST) begin
              wait_q     <= '0;
              dll_ptr_q  <= dll_ptr_q + AW'(1);
              mem_addr_q <= dll_ptr_q + AW'(1);
              if (state_q == S_DLL0) begin
                {dli_q, a12en_q, a11en_q} <= mem_data[7:5];
                offset_q <= mem_data[3:0];
                state_q  <= S_DLL1;
              end else if (state_q == S_DLL1) begin
                dp_q[15:8] <= mem_data;
                state_q    <= S_DLL2;
              end else begin
                dp_q[7:0]  <= mem_data;
                state_q    <= S_FIN;
                mem_req_q  <= 1'b0;
              end
            end
          end
          S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_HDR4: begin
            if (wait_q == RAM_LAST) begin
              wait_q     <= '0;
              dl_ptr_q   <= dl_ptr_q + 16'd1;
              mem_addr_q <= AW'(dl_ptr_q + 16'd1);
              case (state_q)
                S_HDR0: begin
                  lo_q    <= mem_data;
                  state_q <= S_HDR1;
                end
                S_HDR1: begin
                  if (!mem_data[6] && mem_data[4:0] == 5'd0) begin
                    if (offset_q != 4'd0) begin
                      offset_q  <= offset_q - 4'd1;
                      state_q   <= S_FIN;
                      mem_req_q <= 1'b0;
                    end else begin
                      state_q    <= S_DLL0;
                      mem_addr_q <= dll_ptr_q;
                    end
                  end else if (mem_data[4:0] == 5'd0) begin
                    five_q  <= 1'b1;
                    wm_q    <= mem_data[7];
                    ind_q   <= mem_data[5];
                    state_q <= S_HDR2;
                  end else begin
                    five_q           <= 1'b0;
                    {pal_q, w_q}     <= mem_data;
                    ind_q            <= 1'b0;
                    state_q          <= S_HDR2;
                  end
                end
                S_HDR2: begin
                  base_q  <= ind_q ? mem_data : mem_data + off8;
                  hole_q  <= hole_hit;
                  state_q <= five_q ? S_HDR3 : S_HDR4;
                end
                S_HDR3: begin
                  {pal_q, w_q} <= mem_data;
                  state_q      <= S_HDR4;
                end
                default: begin
                  hpos_q   <= mem_data;
                  cnt_q    <= 6'd32 - {1'b0, w_q};
                  newobj_q <= 1'b1;
                  second_q <= 1'b0;
                  gaddr_q  <= {base_q, lo_q};
                  if (hole_q) begin
                    mem_addr_q <= mem_addr_q;
                    state_q    <= S_HOLE;
                  end else begin
                    mem_addr_q <= AW'({base_q, lo_q});
                    state_q    <= ind_q ? S_IND_PTR : S_DIRECT;
                  end
                end
              endcase
            end
          end
          S_HOLE: begin
            if (wait_q == (ind_q ? ROM2_LAST : ROM_LAST)) begin
              wait_q     <= '0;
              mem_addr_q <= AW'(dl_ptr_q);
              state_q    <= S_HDR0;
            end
          end
          S_IND_PTR: begin
            if (wait_q == RAM_LAST) begin
              wait_q     <= '0;
              char_q     <= mem_data;
              second_q   <= 1'b0;
              mem_addr_q <= AW'({char_hi, mem_data});
              state_q    <= S_IND_BYTE;
            end
          end
          S_DIRECT, S_IND_BYTE: begin
            if (stall) begin
              wait_q <= wait_q;
            end else if (wait_q == ROM_LAST) begin
              wait_q   <= '0;
              newobj_q <= 1'b0;
              if (state_q == S_IND_BYTE && char_width && !second_q) begin
                second_q   <= 1'b1;
                mem_addr_q <= AW'({char_hi, char_q + 8'd1});
              end else if (cnt_q == 6'd1) begin
                mem_addr_q <= AW'(dl_ptr_q);
                state_q    <= S_HDR0;
              end else begin
                cnt_q      <= cnt_q - 6'd1;
                gaddr_q    <= gaddr_q + 16'd1;
                mem_addr_q <= AW'(gaddr_q + 16'd1);
                state_q    <= (state_q == S_IND_BYTE) ? S_IND_PTR : S_DIRECT;
              end
            end
          end
          S_FIN: begin
            wait_q    <= '0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Output FIFO; a pop frees the head slot before a same-tick push lands.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (ce) begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_ent;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_maria_dl_fetch_v2.sv
// Scoreboard bench for maria_dl_fetch_v2: memory model, expected FIFO entries
// queued per line, compared as the consumer pops them.
module tb_maria_dl_fetch_v2;
  localparam int unsigned AW         = 16;
  localparam int unsigned WAIT_RAM   = 2;
  localparam int unsigned WAIT_ROM   = 3;
  localparam int unsigned FIFO_DEPTH = 4;

  logic          clk_sys, reset, ce, start, dll_reload, abort;
  logic [AW-1:0] zp;
  logic [7:0]    char_base;
  logic          char_width;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic [7:0]    mem_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_data, out_hpos;
  logic [2:0]    out_pal;
  logic          out_wm, out_newobj, busy, dli;
  logic [9:0]    cycles;

  logic [7:0]  mem [0:65535];
  logic [20:0] sb [$];
  int errors, checks, pops, pushed;
  int n, hole;

  assign mem_data = mem[mem_addr];

  maria_dl_fetch_v2 #(
    .AW(AW), .WAIT_RAM(WAIT_RAM), .WAIT_ROM(WAIT_ROM), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .start(start),
    .dll_reload(dll_reload), .abort(abort), .zp(zp), .char_base(char_base),
    .char_width(char_width), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hpos(out_hpos), .out_pal(out_pal),
    .out_wm(out_wm), .out_newobj(out_newobj), .busy(busy), .dli(dli),
    .cycles(cycles)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_push(input logic [15:0] a, input logic [7:0] h,
                          input logic [2:0] p, input logic w, input logic nw);
    sb.push_back({mem[a], h, p, w, nw});
    pushed++;
  endtask

  task automatic start_line(input logic reload);
    start = 1'b1;
    dll_reload = reload;
    tick();
    start = 1'b0;
    dll_reload = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 2000) begin
      tick();
      cnt++;
    end
    if (cnt >= 2000) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Consumer side: each accepted head is checked against the scoreboard.
  always @(negedge clk_sys) begin
    if (!reset && ce && out_valid && out_ready) begin
      pops++;
      if (sb.size() != 0)
        chk("out", 32'({out_data, out_hpos, out_pal, out_wm, out_newobj}), 32'(sb.pop_front()));
    end
  end

  initial begin
    errors = 0; checks = 0; pops = 0; pushed = 0;
    reset = 1'b1; ce = 1'b1; start = 1'b0; dll_reload = 1'b0; abort = 1'b0;
    zp = 16'h1800; char_base = 8'hC0; char_width = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    mem[16'h1800] = 8'h83; mem[16'h1801] = 8'h20; mem[16'h1802] = 8'h00;
    mem[16'h1803] = 8'h40; mem[16'h1804] = 8'h21; mem[16'h1805] = 8'h00;
    mem[16'h1806] = 8'h00; mem[16'h1807] = 8'h22; mem[16'h1808] = 8'h00;
    mem[16'h1809] = 8'h00; mem[16'h180A] = 8'h23; mem[16'h180B] = 8'h00;

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_out", 32'({out_data, out_hpos, out_pal, out_wm, out_newobj, dli}), 32'd0);
    reset = 1'b0;
    tick();

    // Line 1: DLL reload.
    start_line(1'b1);
    chk("l1_addr", 32'(mem_addr), 32'h1800);
    chk("l1_busy", 32'(busy), 32'd1);
    chk("l1_req", 32'(mem_req), 32'd1);
    wait_idle(n);
    chk("l1_ticks", 32'(n), 32'(3 * WAIT_RAM + 1));
    chk("l1_cycles", 32'(cycles), 32'(3 * WAIT_RAM + 1));
    chk("l1_dli", 32'(dli), 32'd1);
    chk("l1_req_off", 32'(mem_req), 32'd0);

    // Line 2: end-of-list header, offset 3 -> 2.
    mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h00;
    start_line(1'b0);
    chk("l2_addr", 32'(mem_addr), 32'h2000);
    wait_idle(n);
    chk("l2_ticks", 32'(n), 32'(2 * WAIT_RAM + 1));
    chk("l2_cycles", 32'(cycles), 32'(2 * WAIT_RAM + 1));

    // Line 3: 4-byte direct header at offset 2.
    mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h5E; mem[16'h2002] = 8'hA0;
    mem[16'h2003] = 8'h10; mem[16'h2004] = 8'h00; mem[16'h2005] = 8'h00;
    exp_push(16'hA200, 8'h10, 3'd2, 1'b0, 1'b1);
    exp_push(16'hA201, 8'h10, 3'd2, 1'b0, 1'b0);
    start_line(1'b0);
    wait_idle(n);

    // Line 4: 5-byte indirect header, two-byte chars, pointer 0xFF wraps.
    char_width = 1'b1;
    mem[16'h2000] = 8'h40; mem[16'h2001] = 8'hE0; mem[16'h2002] = 8'h30;
    mem[16'h2003] = 8'hBF; mem[16'h2004] = 8'h55; mem[16'h2005] = 8'h00;
    mem[16'h2006] = 8'h00; mem[16'h3040] = 8'hFF;
    exp_push(16'hC1FF, 8'h55, 3'd5, 1'b1, 1'b1);
    exp_push(16'hC100, 8'h55, 3'd5, 1'b1, 1'b0);
    start_line(1'b0);
    wait_idle(n);
    char_width = 1'b0;

    // Line 5: end at offset 0 chains into the next DLL entry.
    mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h00;
    start_line(1'b0);
    wait_idle(n);
    chk("l5_ticks", 32'(n), 32'(5 * WAIT_RAM + 1));
    chk("l5_dli", 32'(dli), 32'd0);

    // Line 6: holey object skipped, then 8-byte object against a blocked consumer.
    out_ready = 1'b0;
    mem[16'h2100] = 8'h00; mem[16'h2101] = 8'h1E; mem[16'h2102] = 8'h90; mem[16'h2103] = 8'h20;
    mem[16'h2104] = 8'h00; mem[16'h2105] = 8'h40; mem[16'h2106] = 8'h50;
    mem[16'h2107] = 8'h18; mem[16'h2108] = 8'h33;
    mem[16'h2109] = 8'h00; mem[16'h210A] = 8'h00;
    for (int k = 0; k < 8; k++) exp_push(16'h5000 + 16'(k), 8'h33, 3'd0, 1'b0, k == 0);
    start_line(1'b0);
    hole = 0;
    for (int k = 0; k < 400 && mem_addr != 16'h5004; k++) begin
      if (mem_addr == 16'h2103) hole++;
      tick();
    end
    chk("hole_len", 32'(hole), 32'(WAIT_RAM + WAIT_ROM));
    chk("stall_addr", 32'(mem_addr), 32'h5004);
    repeat (20) tick();
    chk("stall_hold", 32'(mem_addr), 32'h5004);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_pops", 32'(pops), 32'(pushed - 8));
    out_ready = 1'b1;
    wait_idle(n);

    // Line 7: abort during the third direct byte at offset 0.
    mem[16'h2200] = 8'h00; mem[16'h2201] = 8'h40; mem[16'h2202] = 8'h60;
    mem[16'h2203] = 8'h18; mem[16'h2204] = 8'h44;
    exp_push(16'h6000, 8'h44, 3'd0, 1'b0, 1'b1);
    exp_push(16'h6001, 8'h44, 3'd0, 1'b0, 1'b0);
    start_line(1'b0);
    for (int k = 0; k < 400 && mem_addr != 16'h6002; k++) tick();
    chk("abort_arm", 32'(mem_addr), 32'h6002);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_dll", 32'(mem_addr), 32'h1809);
    chk("abort_busy", 32'(busy), 32'd1);
    wait_idle(n);
    chk("abort_ticks", 32'(n), 32'(3 * WAIT_RAM + 1));

    // Line 8: start together with abort is ignored.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_req", 32'(mem_req), 32'd0);
    tick();
    chk("sa_busy2", 32'(busy), 32'd0);

    repeat (10) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("pop_count", 32'(pops), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
